// File: rtl/inst_mem_fetch_if.sv
// Fetch/response/load bundle between an instruction consumer and inst_mem_fetch.
// Signal names follow the fetch block's external pin names.
interface inst_mem_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] Inst_Address;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] Instruction;
    logic [1:0]  rsp_fault;
    logic        load_valid;
    logic [63:0] load_addr;
    logic [7:0]  load_data;
    logic        busy;

    modport slave (
        input  req_valid, Inst_Address, rsp_ready, load_valid, load_addr, load_data,
        output req_ready, rsp_valid, Instruction, rsp_fault, busy
    );

    modport master (
        output req_valid, Inst_Address, rsp_ready, load_valid, load_addr, load_data,
        input  req_ready, rsp_valid, Instruction, rsp_fault, busy
    );
endinterface

// File: rtl/inst_mem_fetch.sv
// Byte-addressed instruction memory with 32-bit little-endian fetch and fault codes; INST_MEM_LOAD_PORT_EN enables the byte load port.
// Latency: rsp_valid rises LATENCY+1 edges after the accepting edge (first RESP cycle registers the read).
// Backpressure: response held stable until rsp_ready; one request in flight, req_ready low while busy or loading.
module inst_mem_fetch #(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned LATENCY     = 1
) (
    input logic           clk,
    input logic           reset_n,
    inst_mem_fetch_if.slave bus
);

    localparam int unsigned AW        = $clog2(DEPTH_BYTES);
    localparam logic [63:0] DEPTH64   = 64'(DEPTH_BYTES);
    localparam logic [63:0] LAST_WORD = 64'(DEPTH_BYTES - 4);
    localparam logic [2:0]  LAT_M1    = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [63:0] addr_q;
    logic        rsp_valid_q;
    logic        busy_q;
    logic [31:0] inst_q;
    logic [1:0]  fault_q;

    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [1:0]    fault_d;

    assign idx = addr_q[AW-1:0];

`ifdef INST_MEM_LOAD_PORT_EN
    // Boot word 0x00300293 at bytes 0..3; contents survive reset.
    logic [7:0] mem_q [DEPTH_BYTES] = '{0: 8'h93, 1: 8'h02, 2: 8'h30, default: 8'h00};
    logic       load_en;

    assign load_en       = (state_q == IDLE) && bus.load_valid;
    assign bus.req_ready = (state_q == IDLE) && !bus.load_valid;

    always_ff @(posedge clk) begin
        if (load_en && (bus.load_addr < DEPTH64)) begin
            mem_q[bus.load_addr[AW-1:0]] <= bus.load_data;
        end
    end

    assign rd_word = {mem_q[idx + AW'(3)], mem_q[idx + AW'(2)],
                      mem_q[idx + AW'(1)], mem_q[idx]};
`else
    // Read-only build: the memory is the fixed boot image.
    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        logic [7:0] b;
        b = 8'h00;
        if (a == AW'(0))      b = 8'h93;
        else if (a == AW'(1)) b = 8'h02;
        else if (a == AW'(2)) b = 8'h30;
        return b;
    endfunction

    logic unused_load;
    assign unused_load   = ^{bus.load_valid, bus.load_addr, bus.load_data};
    assign bus.req_ready = (state_q == IDLE);

    assign rd_word = {rom_byte(idx + AW'(3)), rom_byte(idx + AW'(2)),
                      rom_byte(idx + AW'(1)), rom_byte(idx)};
`endif

    // Misalignment wins over range; range check uses all 64 bits so high addresses never alias.
    always_comb begin
        fault_d = 2'b00;
        if (addr_q[1:0] != 2'b00) begin
            fault_d = 2'b01;
        end else if (addr_q > LAST_WORD) begin
            fault_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 64'd0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            inst_q      <= 32'd0;
            fault_q     <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        addr_q <= bus.Inst_Address;
                        busy_q <= 1'b1;
                        if (LATENCY > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= LAT_M1;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        fault_q     <= fault_d;
                        inst_q      <= (fault_d == 2'b00) ? rd_word : 32'd0;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        fault_q     <= 2'b00;
                        inst_q      <= 32'd0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.Instruction = inst_q;
    assign bus.rsp_fault   = fault_q;
    assign bus.busy        = busy_q;

endmodule
